hdmi_stream_timing: RTL and testbench
=====================================

Name: hdmi_stream_timing

Overview:
- Upstream neighbour of the HDMI output stage and the PPM frame logger.
- Converts a valid/ready RGB pixel stream carrying start-of-frame markers into raster timing: hdmi_vs, hdmi_hs, hdmi_de, hdmi_data.
- Frame geometry is parameterised; defaults give an 800x300 active image, matching the logger's expected frame size.
- Handles stream underflow and misalignment by emitting a fill colour and resynchronising on the next start of frame.

Parameters:
- H_ACTIVE, 800, active pixels per line
- H_FP, 40, horizontal front porch, clocks
- H_SYNC, 128, horizontal sync width, clocks
- H_BP, 88, horizontal back porch, clocks
- V_ACTIVE, 300, active lines per frame
- V_FP, 1, vertical front porch, lines
- V_SYNC, 4, vertical sync width, lines
- V_BP, 23, vertical back porch, lines
- FILL_RGB, 24'h000000, colour emitted when no valid pixel is available

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  24  pixel, {R[23:16],G[15:8],B[7:0]}
- in_sof  in  1  marks the first pixel of a frame
- in_valid  in  1  pixel valid
- in_ready  out  1  pixel accepted when in_valid & in_ready
- hdmi_vs  out  1  vertical sync, active-high
- hdmi_hs  out  1  horizontal sync, active-high
- hdmi_de  out  1  data enable
- hdmi_data  out  32  {8'h00, R, G, B}
- frame_start  out  1  one-cycle pulse coincident with the first hdmi_de of each frame
- underflow  out  1  sticky error flag, set on underflow or misalignment; cleared only by rst

Behaviour:
- Counters
  - h_cnt runs 0..H_TOTAL-1; v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1.
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined likewise.
  - Active position: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - Counter widths are clog2(H_TOTAL) and clog2(V_TOTAL).
- Sync decode
  - hs is high for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs is high for whole lines with v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Latency
  - All hdmi_* outputs and frame_start are registered.
  - Each output reflects the counter position and accepted pixel of the previous cycle (latency 1).
- Reset
  - h_cnt=0, v_cnt=V_ACTIVE, state=WAIT_SOF.
  - All outputs are 0, including in_ready, hdmi_data and underflow.
  - The first frame is therefore preceded by a complete vsync pulse, so downstream sees a falling vs edge before the first active pixel.
- FSM state WAIT_SOF
  - At a non-(0,0) position: in_ready = in_valid & ~in_sof. Non-sof pixels are flushed; a sof pixel is held.
  - At active (0,0) with in_valid & in_sof: the pixel is consumed and the state moves to RUN.
  - Any active position without a consumed pixel outputs FILL_RGB; de still follows the counters.
- FSM state RUN
  - in_ready = 1 at active positions and 0 elsewhere.
  - Active position with in_valid=0: emit FILL_RGB, set underflow, go to WAIT_SOF.
  - in_sof=1 at a non-(0,0) position: the pixel is not consumed (in_ready=0 that cycle), FILL_RGB is emitted, underflow is set, go to WAIT_SOF.
  - At (0,0), in_valid with in_sof=0: the pixel is not consumed, FILL_RGB is emitted, underflow is set, go to WAIT_SOF.
- Simultaneous events
  - Underflow and misalignment in the same cycle set underflow once.
  - Counter wrap takes priority over nothing; counters never stall.
- Blanking: outside active positions hdmi_data=0 and de=0.
- Reset mid-frame
  - Outputs drop to 0 immediately (async).
  - Counters restart in front porch as above; no partial de follows reset release.

Optional Feature:
- Macro: HDMI_STREAM_TPG_EN.
- When defined:
  - Adds input port tpg_sel (1 bit).
  - With tpg_sel=1: the block outputs 8 vertical colour bars, each H_ACTIVE/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black.
  - in_ready is held 0, the FSM is forced to WAIT_SOF, and underflow is not updated.
- When not defined: no tpg_sel port; behaviour is stream-only.

Decomposition:
- Package hdmi_video_pkg holds:
  - default timing constants (800x300 set);
  - the RGB24 typedef;
  - the state enum {WAIT_SOF, RUN};
  - the colour-bar table.
- One sub-module, hdmi_timing_counter, holds the h/v counters plus the active/hs/vs decode. It is reusable by the test-pattern path and by the bench.

Test Plan:
- Reset release, no stream:
  - First rising vs occurs at v_cnt=V_ACTIVE+V_FP (line 301).
  - Then 300 lines x 800 de cycles with hdmi_data=32'h0000_0000.
  - underflow stays 0.
- Continuous stream with sof on pixel 0, data=pixel index:
  - Exactly 240000 de beats per frame.
  - hdmi_data[23:0] follows the index with 1-cycle latency.
  - frame_start pulses once, coincident with the first de.
- Stall in_valid at line 10, pixel 5:
  - That beat is FILL_RGB and underflow=1.
  - Rest of the frame is fill.
  - Next frame recovers on sof and shows correct data.
- sof asserted at pixel 400 of line 0:
  - in_ready=0 that cycle and underflow=1.
  - That pixel becomes the (0,0) pixel of the following frame.
- rst pulsed mid-frame at line 150:
  - All outputs go 0 asynchronously.
  - After release, a full vsync pulse precedes the next de.
- HDMI_STREAM_TPG_EN with tpg_sel=1: pixels 0, 100 and 799 read 0xFFFFFF, 0xFFFF00 and 0x000000; in_ready stays 0.

Source files
------------

// File: rtl/hdmi_video_pkg.sv
// hdmi_video_pkg: timing defaults (800x300 raster), RGB24 pixel type, stream FSM states
// and the eight-entry colour-bar table used by the optional test-pattern path.
package hdmi_video_pkg;

    localparam int unsigned DEF_H_ACTIVE = 800;
    localparam int unsigned DEF_H_FP     = 40;
    localparam int unsigned DEF_H_SYNC   = 128;
    localparam int unsigned DEF_H_BP     = 88;
    localparam int unsigned DEF_V_ACTIVE = 300;
    localparam int unsigned DEF_V_FP     = 1;
    localparam int unsigned DEF_V_SYNC   = 4;
    localparam int unsigned DEF_V_BP     = 23;
    localparam logic [23:0] DEF_FILL_RGB = 24'h000000;

    // {R[23:16], G[15:8], B[7:0]}
    typedef logic [23:0] rgb24_t;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        RUN      = 1'b1
    } state_t;

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic rgb24_t bar_colour(input logic [2:0] idx);
        rgb24_t c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hdmi_timing_counter.sv
// hdmi_timing_counter: free-running h/v raster counters with active/hsync/vsync decode.
// Reset parks the raster at the first front-porch line so a full vsync precedes frame 0.
module hdmi_timing_counter
    import hdmi_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int unsigned VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          hs,
    output logic          vs
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    // Raster counters: h wraps every line, v advances on each h wrap; never stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= V_ACT_C;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Position decode for the current counter values.
    always_comb begin
        active = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        hs     = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs     = (v_cnt >= VS_START) && (v_cnt < VS_END);
    end

endmodule

// File: rtl/hdmi_stream_timing.sv
// hdmi_stream_timing: turns a valid/ready RGB stream with start-of-frame markers into
// registered HDMI raster timing. Underflow or misalignment emits fill colour, sets a sticky
// flag and waits for the next sof at the frame origin.
// Optional HDMI_STREAM_TPG_EN adds tpg_sel, which replaces the stream with 8 colour bars.
module hdmi_stream_timing
    import hdmi_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic [23:0] FILL_RGB = DEF_FILL_RGB
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] in_data,
    input  logic        in_sof,
    input  logic        in_valid,
`ifdef HDMI_STREAM_TPG_EN
    input  logic        tpg_sel,
`endif
    output logic        in_ready,
    output logic        hdmi_vs,
    output logic        hdmi_hs,
    output logic        hdmi_de,
    output logic [31:0] hdmi_data,
    output logic        frame_start,
    output logic        underflow
);

    localparam int unsigned HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int unsigned VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active, hs, vs, origin;
    logic          tpg_on;
    rgb24_t        tpg_rgb;
    state_t        state, state_d;
    logic          ready_c, take_c, err_c;
    rgb24_t        pix_c;

    hdmi_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .active (active),
        .hs     (hs),
        .vs     (vs)
    );

    assign origin = (h_cnt == '0) && (v_cnt == '0);

`ifdef HDMI_STREAM_TPG_EN
    localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    int unsigned bar_pos;
    logic [2:0]  bar_idx;

    // Bar index from the horizontal position; any remainder columns stay in the last bar.
    always_comb begin
        bar_pos = 32'(h_cnt) / BAR_W;
        bar_idx = (bar_pos > 7) ? 3'd7 : bar_pos[2:0];
    end

    assign tpg_on  = tpg_sel;
    assign tpg_rgb = bar_colour(bar_idx);
`else
    assign tpg_on  = 1'b0;
    assign tpg_rgb = FILL_RGB;
`endif

    // Handshake and next-state decode for the stream FSM.
    always_comb begin
        ready_c = 1'b0;
        take_c  = 1'b0;
        err_c   = 1'b0;
        state_d = state;
        if (tpg_on) begin
            state_d = WAIT_SOF;
        end else begin
            unique case (state)
                WAIT_SOF: begin
                    if (origin) begin
                        // Anything at the origin is taken; only a sof starts the frame.
                        ready_c = in_valid;
                        if (in_valid && in_sof) begin
                            take_c  = 1'b1;
                            state_d = RUN;
                        end
                    end else begin
                        // Flush stale pixels but hold a sof until the origin comes round.
                        ready_c = in_valid && !in_sof;
                    end
                end
                RUN: begin
                    if (active) begin
                        if (!in_valid) begin
                            ready_c = 1'b1;
                            err_c   = 1'b1;
                            state_d = WAIT_SOF;
                        end else if (in_sof != origin) begin
                            err_c   = 1'b1;
                            state_d = WAIT_SOF;
                        end else begin
                            ready_c = 1'b1;
                            take_c  = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready = ready_c && !rst;

    // Pixel selection for the active position.
    always_comb begin
        pix_c = FILL_RGB;
        if (tpg_on) begin
            pix_c = tpg_rgb;
        end else if (take_c) begin
            pix_c = in_data;
        end
    end

    // FSM state and all registered outputs, one cycle behind the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_SOF;
            hdmi_vs     <= 1'b0;
            hdmi_hs     <= 1'b0;
            hdmi_de     <= 1'b0;
            hdmi_data   <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            state       <= state_d;
            hdmi_vs     <= vs;
            hdmi_hs     <= hs;
            hdmi_de     <= active;
            hdmi_data   <= active ? {8'h00, pix_c} : 32'h0;
            frame_start <= origin;
            if (err_c) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_stream_timing.sv
// tb_hdmi_stream_timing: directed frames on a reduced 16x6 raster. Stimulus pushes expected
// de beats into a queue; a negedge monitor pops and compares every beat it sees.
module tb_hdmi_stream_timing;

    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 3;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int NPIX = HA * VA;

    typedef struct packed {
        logic [23:0] data;
        logic        fs;
        logic        uf;
    } beat_t;

    typedef struct packed {
        logic        stall;
        logic        sof;
        logic [23:0] data;
    } src_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] in_data = '0;
    logic        in_sof = 1'b0;
    logic        in_valid = 1'b0;
    logic        tpg_sel = 1'b0;
    logic        in_ready, hdmi_vs, hdmi_hs, hdmi_de, frame_start, underflow;
    logic [31:0] hdmi_data;

    int    n_vec = 0;
    int    n_err = 0;
    beat_t exp_q[$];
    src_t  src_q[$];
    beat_t b;
    int    ph = 0, pv = VA, frame_no = 0;
    logic  e_de = 1'b0, e_hs = 1'b0, e_vs = 1'b0;
    logic  acc = 1'b0;
    logic  vs_seen = 1'b0;
    logic  chk_vs = 1'b1;
    logic [23:0] bars [8];

    always #5 clk = ~clk;

    hdmi_stream_timing #(
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HS),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VS),
        .V_BP     (VBP),
        .FILL_RGB (24'h000000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_sof      (in_sof),
        .in_valid    (in_valid),
`ifdef HDMI_STREAM_TPG_EN
        .tpg_sel     (tpg_sel),
`endif
        .in_ready    (in_ready),
        .hdmi_vs     (hdmi_vs),
        .hdmi_hs     (hdmi_hs),
        .hdmi_de     (hdmi_de),
        .hdmi_data   (hdmi_data),
        .frame_start (frame_start),
        .underflow   (underflow)
    );

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic logic [23:0] pix(input int f, input int i);
        return 24'((f << 16) | i);
    endfunction

    // Stream of npix pixels for frame f; a one-cycle valid gap is inserted before pixel stall_at.
    task automatic add_src(input int f, input int npix, input int stall_at);
        for (int i = 0; i < npix; i++) begin
            if (i == stall_at) src_q.push_back({1'b1, 1'b0, 24'h0});
            src_q.push_back({1'b0, (i == 0), pix(f, i)});
        end
    endtask

    // Expected de beats: first n_data carry frame data, the rest fill; underflow from uf_from on.
    task automatic add_exp(input int f, input int n_data, input int uf_from, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            exp_q.push_back({(i < n_data) ? pix(f, i) : 24'h000000, (i == 0), (i >= uf_from)});
        end
    endtask

    task automatic wait_pos(input int f, input int h, input int v, input string name);
        int cyc = 0;
        while (!(frame_no == f && ph == h && pv == v) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 4000) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: position f%0d (%0d,%0d) not reached, at f%0d (%0d,%0d)",
                     name, f, h, v, frame_no, ph, pv);
        end
    endtask

    // Reference raster position and the sync/de levels the DUT should show one cycle later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph   <= 0;
            pv   <= VA;
            e_de <= 1'b0;
            e_hs <= 1'b0;
            e_vs <= 1'b0;
        end else begin
            e_de <= (ph < HA) && (pv < VA);
            e_hs <= (ph >= HA + HFP) && (ph < HA + HFP + HS);
            e_vs <= (pv >= VA + VFP) && (pv < VA + VFP + VS);
            if (ph == HT - 1) begin
                ph <= 0;
                if (pv == VT - 1) begin
                    pv       <= 0;
                    frame_no <= frame_no + 1;
                end else begin
                    pv <= pv + 1;
                end
            end else begin
                ph <= ph + 1;
            end
        end
    end

    // Source driver: presents the queue head, pops it once accepted (or after a one-cycle gap).
    initial begin
        forever begin
            @(negedge clk);
            if (src_q.size() > 0 && (acc || src_q[0].stall)) void'(src_q.pop_front());
            if (src_q.size() > 0 && !src_q[0].stall) begin
                in_valid = 1'b1;
                in_sof   = src_q[0].sof;
                in_data  = src_q[0].data;
            end else begin
                in_valid = 1'b0;
                in_sof   = 1'b0;
                in_data  = '0;
            end
            #1;
            acc = in_valid && in_ready;
            if (!rst && tpg_sel && in_valid) begin
                check("tpg_in_ready", 64'(in_ready), 64'(0));
            end else if (!rst && in_valid && in_sof) begin
                check("sof_in_ready", 64'(in_ready), 64'(ph == 0 && pv == 0));
            end
        end
    end

    // Monitor: sync/de levels every cycle, scoreboard pop on every de beat.
    always @(negedge clk) begin
        check("timing_de_hs_vs", 64'({hdmi_de, hdmi_hs, hdmi_vs}), 64'({e_de, e_hs, e_vs}));
        if (hdmi_vs) vs_seen = 1'b1;
        if (hdmi_de) begin
            if (chk_vs) begin
                check("vs_before_de", 64'(vs_seen), 64'(1));
                chk_vs = 1'b0;
            end
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL beat_extra: got de beat %0h, expected none", hdmi_data);
            end else begin
                b = exp_q.pop_front();
                check("beat_data", 64'(hdmi_data), 64'({8'h00, b.data}));
                check("beat_frame_start", 64'(frame_start), 64'(b.fs));
                check("beat_underflow", 64'(underflow), 64'(b.uf));
            end
        end else begin
            check("blank_data_fs", 64'({hdmi_data, frame_start}), 64'(0));
        end
    end

    initial begin
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        // Reset with a pixel offered: everything must read 0, including in_ready.
        src_q.push_back({1'b0, 1'b0, 24'hABCDEF});
        repeat (3) @(negedge clk);
        #2;
        check("reset_outputs",
              64'({in_ready, hdmi_vs, hdmi_hs, hdmi_de, hdmi_data, frame_start, underflow}),
              64'(0));
        @(negedge clk);
        #2 rst = 1'b0;

        // Frame 1: no stream, all fill.
        add_exp(1, 0, NPIX, NPIX);
        wait_pos(1, 0, 1, "load_point");
        // Frame 2 clean, 3 stalls at line 2 pixel 5, 4 recovers,
        // 5 is cut short by frame 6's sof at pixel 8, 7 is interrupted by reset.
        add_src(2, NPIX, -1);
        add_src(3, NPIX, 2 * HA + 5);
        add_src(4, NPIX, -1);
        add_src(5, 8, -1);
        add_src(6, NPIX, -1);
        add_src(7, NPIX, -1);
        add_exp(2, NPIX, NPIX, NPIX);
        add_exp(3, 2 * HA + 5, 2 * HA + 5, NPIX);
        add_exp(4, NPIX, 0, NPIX);
        add_exp(5, 8, 0, NPIX);
        add_exp(6, NPIX, 0, NPIX);
        add_exp(7, 3 * HA + 5, 0, 3 * HA + 5);

        // Mid-frame reset while a data beat is on the outputs.
        wait_pos(7, 5, 3, "mid_frame");
        #2;
        rst = 1'b1;
        src_q.delete();
        vs_seen = 1'b0;
        chk_vs  = 1'b1;
        #1;
        check("async_reset_outputs",
              64'({in_ready, hdmi_vs, hdmi_hs, hdmi_de, hdmi_data, frame_start, underflow}),
              64'(0));
        check("frame7_beats_left", 64'(exp_q.size()), 64'(0));
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // Frame 8 after reset: fill only, underflow cleared.
        add_exp(8, 0, NPIX, NPIX);

`ifdef HDMI_STREAM_TPG_EN
        wait_pos(8, 0, VA, "tpg_switch");
        tpg_sel = 1'b1;
        src_q.push_back({1'b0, 1'b0, 24'h00AA55});
        for (int i = 0; i < NPIX; i++) begin
            exp_q.push_back({bars[(i % HA) / (HA / 8)], (i == 0), 1'b0});
        end
`endif

        begin
            int cyc = 0;
            while (exp_q.size() > 0 && cyc < 3000) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("all_beats_seen", 64'(exp_q.size()), 64'(0));
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
